eth_fcs_inserter: RTL and testbench

- Downstream neighbour of the IPv4 packet transmitter. Sits between the transmitter's 8-bit AXI-Stream output and the MAC TX interface.
- Passes frame bytes through unchanged, zero-pads short frames to the Ethernet minimum, and appends the 4-byte CRC-32 FCS.
- Enforces an inter-frame idle gap after every frame, so the transmitter no longer needs to emit padding or the FCS itself.

---
 rtl/eth_fcs_inserter.sv | 163 ++++++++++++++++
 tb/tb_eth_fcs_inserter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_fcs_inserter.sv
// Ethernet FCS inserter: passes frame bytes through, zero-pads short frames to the minimum
// length, appends the reflected CRC-32 FCS and enforces an idle gap before the next frame.
module eth_fcs_inserter #(
  parameter int unsigned MIN_FRAME_BYTES = 60,
  parameter int unsigned IFG_CYCLES      = 12,
  parameter int unsigned COUNT_WIDTH     = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [7:0]             S_DATA_IN,
  input  logic                   S_DATA_VALID,
  output logic                   S_DATA_READY,
  input  logic                   S_DATA_LAST,
  input  logic                   S_DATA_TUSER,
  output logic [7:0]             M_DATA_OUT,
  output logic                   M_DATA_VALID,
  input  logic                   M_DATA_READY,
  output logic                   M_DATA_LAST,
  output logic                   M_DATA_TUSER,
  output logic [COUNT_WIDTH-1:0] FRAME_COUNT,
  output logic                   BUSY
);

  localparam logic [31:0] CrcPoly = 32'hEDB88320;
  localparam logic [31:0] CrcInit = 32'hFFFFFFFF;
  localparam int unsigned GapW    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'((IFG_CYCLES == 0) ? 0 : IFG_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] MinCnt = COUNT_WIDTH'(MIN_FRAME_BYTES);

  typedef enum logic [2:0] {StIdle, StPass, StPad, StFcs, StGap} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            crc_q, crc_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [GapW-1:0]        gap_q, gap_d;
  logic [1:0]             idx_q, idx_d;
  logic                   err_q, err_d;
  logic [COUNT_WIDTH-1:0] frames_q, frames_d;
  logic [31:0]            fcs_word;
  logic [7:0]             fcs_byte;
  logic                   in_xfer, out_xfer;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + COUNT_WIDTH'(1);
  assign fcs_word = ~crc_q;
  assign fcs_byte = fcs_word[{idx_q, 3'b000} +: 8];
  assign in_xfer  = S_DATA_VALID & S_DATA_READY;
  assign out_xfer = M_DATA_VALID & M_DATA_READY;

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state_q  <= StIdle;
      crc_q    <= CrcInit;
      cnt_q    <= '0;
      gap_q    <= '0;
      idx_q    <= 2'd0;
      err_q    <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      frames_q <= frames_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    idx_d    = idx_q;
    err_d    = err_q;
    frames_d = frames_q;
    unique case (state_q)
      // The first byte of a frame is handled exactly like any later payload byte.
      StIdle, StPass: begin
        if (in_xfer) begin
          crc_d   = crc_byte(crc_q, S_DATA_IN);
          cnt_d   = cnt_inc;
          err_d   = err_q | S_DATA_TUSER;
          state_d = StPass;
          if (S_DATA_LAST) begin
            state_d = (cnt_inc < MinCnt) ? StPad : StFcs;
          end
        end
      end
      StPad: begin
        if (out_xfer) begin
          crc_d = crc_byte(crc_q, 8'h00);
          cnt_d = cnt_inc;
          if (cnt_inc >= MinCnt) begin
            state_d = StFcs;
          end
        end
      end
      StFcs: begin
        if (out_xfer) begin
          if (idx_q == 2'd3) begin
            idx_d    = 2'd0;
            frames_d = frames_q + COUNT_WIDTH'(1);
            crc_d    = CrcInit;
            cnt_d    = '0;
            err_d    = 1'b0;
            gap_d    = '0;
            state_d  = (IFG_CYCLES == 0) ? StIdle : StGap;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pass-through is gated by reset so every output reads 0 while ARESET is low.
  always_comb begin
    S_DATA_READY = 1'b0;
    M_DATA_OUT   = 8'h00;
    M_DATA_VALID = 1'b0;
    M_DATA_LAST  = 1'b0;
    M_DATA_TUSER = 1'b0;
    if (ARESET) begin
      unique case (state_q)
        StIdle, StPass: begin
          S_DATA_READY = M_DATA_READY;
          M_DATA_OUT   = S_DATA_IN;
          M_DATA_VALID = S_DATA_VALID;
        end
        StPad: M_DATA_VALID = 1'b1;
        StFcs: begin
          M_DATA_VALID = 1'b1;
          M_DATA_OUT   = fcs_byte;
          M_DATA_LAST  = (idx_q == 2'd3);
          M_DATA_TUSER = err_q & (idx_q == 2'd3);
        end
        default: ;
      endcase
    end
  end

  assign BUSY        = (state_q != StIdle);
  assign FRAME_COUNT = frames_q;

endmodule

// File: tb/tb_eth_fcs_inserter.sv
// Self-checking bench for eth_fcs_inserter: table of frames checked through an output
// scoreboard, plus hand sequences for the CRC check vector, inter-frame gap and reset.
`timescale 1ns/1ps
module tb_eth_fcs_inserter;

  localparam int MinBytes = 60;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       tuser;
  } out_t;

  typedef struct {
    int len;
    int tuser_pos;
    bit gaps;
    bit rnd_ready;
    int exp_out;
  } vec_t;

  logic        aclk = 1'b0;
  logic        areset = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0, s_last = 1'b0, s_tuser = 1'b0;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid, m_last, m_tuser;
  logic        m_ready = 1'b1;
  logic [15:0] frame_count;
  logic        busy;

  logic [7:0]  s9_data = 8'h00;
  logic        s9_valid = 1'b0, s9_last = 1'b0;
  logic        s9_ready;
  logic [7:0]  m9_data;
  logic        m9_valid, m9_last, m9_tuser;
  logic [15:0] fc9;
  logic        busy9;

  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_fc = 0;
  int   mon_frames = 0;
  int   mon_len = 0;
  int   mon_last_len = 0;
  bit   sb_en = 1'b1;
  bit   rand_ready = 1'b0;
  bit   stall_q = 1'b0;
  logic [7:0] stall_data = 8'h00;
  out_t exp_q[$];

  always #5 aclk = ~aclk;

  eth_fcs_inserter dut (
    .ACLK(aclk), .ARESET(areset),
    .S_DATA_IN(s_data), .S_DATA_VALID(s_valid), .S_DATA_READY(s_ready),
    .S_DATA_LAST(s_last), .S_DATA_TUSER(s_tuser),
    .M_DATA_OUT(m_data), .M_DATA_VALID(m_valid), .M_DATA_READY(m_ready),
    .M_DATA_LAST(m_last), .M_DATA_TUSER(m_tuser),
    .FRAME_COUNT(frame_count), .BUSY(busy)
  );

  eth_fcs_inserter #(.MIN_FRAME_BYTES(9), .IFG_CYCLES(0), .COUNT_WIDTH(16)) dut9 (
    .ACLK(aclk), .ARESET(areset),
    .S_DATA_IN(s9_data), .S_DATA_VALID(s9_valid), .S_DATA_READY(s9_ready),
    .S_DATA_LAST(s9_last), .S_DATA_TUSER(1'b0),
    .M_DATA_OUT(m9_data), .M_DATA_VALID(m9_valid), .M_DATA_READY(1'b1),
    .M_DATA_LAST(m9_last), .M_DATA_TUSER(m9_tuser),
    .FRAME_COUNT(fc9), .BUSY(busy9)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Non-reflected MSB-first formulation; bit-reversed at the end to give the Ethernet FCS.
  function automatic logic [31:0] ref_fcs(input logic [7:0] b[$]);
    logic [31:0] crc, rev;
    logic        fb;
    crc = 32'hFFFFFFFF;
    foreach (b[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb  = crc[31] ^ b[k][i];
        crc = {crc[30:0], 1'b0};
        if (fb) crc = crc ^ 32'h04C11DB7;
      end
    end
    for (int i = 0; i < 32; i++) rev[i] = crc[31-i];
    return ~rev;
  endfunction

  always @(posedge aclk) begin
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor / scoreboard, sampled mid-cycle.
  always @(negedge aclk) begin
    out_t e;
    if (!areset) begin
      mon_len = 0;
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid_held", m_valid, 1);
        check("stall_data_held", m_data, stall_data);
      end
      stall_q    = m_valid && !m_ready;
      stall_data = m_data;
      if (m_valid && m_ready) begin
        mon_len++;
        if (sb_en) begin
          check("sb_expected_byte", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_data", m_data, e.data);
            check("out_last", m_last, e.last);
            check("out_tuser", m_tuser, e.tuser);
          end
        end
        if (m_last) begin
          mon_frames++;
          mon_last_len = mon_len;
          mon_len = 0;
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] bytes[$], input int tpos, input bit gaps);
    bit acc;
    int t;
    for (int i = 0; i < bytes.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge aclk);
        #1;
      end
      s_data  = bytes[i];
      s_valid = 1'b1;
      s_last  = (i == bytes.size() - 1);
      s_tuser = (i == tpos);
      acc = 1'b0;
      t = 0;
      while (!acc) begin
        @(negedge aclk);
        acc = s_ready;
        @(posedge aclk);
        #1;
        t++;
        if (!acc && t > 2000) begin
          check("input_accept_timeout", acc, 1);
          s_valid = 1'b0;
          s_last  = 1'b0;
          s_tuser = 1'b0;
          return;
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_tuser = 1'b0;
  endtask

  task automatic run_frame(input int len, input int tpos, input bit gaps, input int exp_out);
    logic [7:0]  bytes[$];
    logic [7:0]  full[$];
    logic [31:0] fcs;
    out_t        e;
    int          target, t;
    for (int i = 0; i < len; i++) bytes.push_back(8'($urandom_range(0, 255)));
    full = bytes;
    while (full.size() < MinBytes) full.push_back(8'h00);
    fcs = ref_fcs(full);
    foreach (full[i]) begin
      e.data = full[i]; e.last = 1'b0; e.tuser = 1'b0;
      exp_q.push_back(e);
    end
    for (int k = 0; k < 4; k++) begin
      e.data  = fcs[8*k +: 8];
      e.last  = (k == 3);
      e.tuser = (k == 3) && (tpos >= 0) && (tpos < len);
      exp_q.push_back(e);
    end
    target = mon_frames + 1;
    send_frame(bytes, tpos, gaps);
    t = 0;
    while (mon_frames != target && t < 5000) begin
      @(posedge aclk);
      #1;
      t++;
    end
    check("frame_done", mon_frames, target);
    if (mon_frames == target) begin
      check("out_transfers", mon_last_len, exp_out);
      exp_fc++;
      check("frame_count", frame_count, exp_fc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got no end, expected end");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[7];
    logic [7:0] chk9[9];
    logic [7:0] fcs9[4];
    vecs[0] = '{46, -1, 1'b0, 1'b0, 64};
    vecs[1] = '{70, -1, 1'b1, 1'b1, 74};
    vecs[2] = '{60,  4, 1'b0, 1'b0, 64};
    vecs[3] = '{60, -1, 1'b0, 1'b0, 64};
    vecs[4] = '{ 1, -1, 1'b0, 1'b1, 64};
    vecs[5] = '{61, -1, 1'b1, 1'b1, 65};
    vecs[6] = '{59, -1, 1'b0, 1'b0, 64};
    for (int i = 0; i < 9; i++) chk9[i] = 8'h31 + 8'(i);
    fcs9 = '{8'h26, 8'h39, 8'hF4, 8'hCB};

    // Reset state, with pass-through inputs active to show the gating.
    s_valid = 1'b1;
    s_data  = 8'hA5;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_count", frame_count, 0);
    s_valid = 1'b0;
    areset  = 1'b1;
    @(negedge aclk);
    check("idle_s_ready", s_ready, 1);
    check("idle_busy", busy, 0);
    @(posedge aclk);
    #1;

    // CRC check vector "123456789" on the MIN_FRAME_BYTES=9, no-gap instance.
    for (int i = 0; i < 9; i++) begin
      s9_data  = chk9[i];
      s9_valid = 1'b1;
      s9_last  = (i == 8);
      @(negedge aclk);
      check("d9_pass_ready", s9_ready, 1);
      check("d9_pass_data", m9_data, chk9[i]);
      check("d9_pass_last", m9_last, 0);
      @(posedge aclk);
      #1;
    end
    s9_valid = 1'b0;
    s9_last  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      check("d9_fcs_valid", m9_valid, 1);
      check("d9_fcs_data", m9_data, fcs9[k]);
      check("d9_fcs_last", m9_last, (k == 3));
      check("d9_fcs_ready_low", s9_ready, 0);
      @(posedge aclk);
      #1;
    end
    check("d9_frame_count", fc9, 1);
    check("d9_busy_after", busy9, 0);

    // Table of frames through the default-parameter instance.
    foreach (vecs[v]) begin
      rand_ready = vecs[v].rnd_ready;
      run_frame(vecs[v].len, vecs[v].tuser_pos, vecs[v].gaps, vecs[v].exp_out);
      rand_ready = 1'b0;
    end

    // Inter-frame gap: exactly 12 blocked cycles after the final FCS byte.
    @(posedge aclk);
    #1;
    run_frame(50, -1, 1'b0, 64);
    for (int k = 0; k < 12; k++) begin
      @(negedge aclk);
      check("gap_s_ready", s_ready, 0);
      check("gap_m_valid", m_valid, 0);
      check("gap_busy", busy, 1);
    end
    @(negedge aclk);
    check("gap_end_busy", busy, 0);
    check("gap_end_s_ready", s_ready, 1);
    @(posedge aclk);
    #1;
    run_frame(64, -1, 1'b0, 68);

    // Mid-frame reset at pad byte 3 of a 10-byte frame.
    begin
      logic [7:0] short_frame[$];
      @(posedge aclk);
      #1;
      for (int i = 0; i < 10; i++) short_frame.push_back(8'(i + 1));
      while (busy) begin
        @(posedge aclk);
        #1;
      end
      sb_en = 1'b0;
      send_frame(short_frame, -1, 1'b0);
      repeat (3) begin
        @(posedge aclk);
        #1;
      end
      check("pre_rst_pad_valid", m_valid, 1);
      s_valid = 1'b1;
      s_data  = 8'hA5;
      #2;
      areset = 1'b0;
      #1;
      check("midrst_m_valid", m_valid, 0);
      check("midrst_m_data", m_data, 0);
      check("midrst_m_last", m_last, 0);
      check("midrst_m_tuser", m_tuser, 0);
      check("midrst_s_ready", s_ready, 0);
      check("midrst_busy", busy, 0);
      check("midrst_frame_count", frame_count, 0);
      s_valid = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      areset = 1'b1;
      exp_q.delete();
      exp_fc = 0;
      sb_en  = 1'b1;
      #1;
      check("post_rst_busy", busy, 0);
      run_frame(60, -1, 1'b0, 64);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
